// File: rtl/uplink_frame_capture_if.sv
// Readout stream of the uplink frame capture buffer: 32-bit words with valid/ready flow control.
// The master drives data/valid/last; the slave (CDC FIFO / AXI readout) drives ready.
interface uplink_frame_capture_if;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic        rd_last_o;
  logic        rd_ready_i;

  modport master (output rd_data_o, output rd_valid_o, output rd_last_o, input rd_ready_i);
  modport slave  (input rd_data_o, input rd_valid_o, input rd_last_o, output rd_ready_i);
endinterface

// File: rtl/uplink_frame_capture.sv
// Triggered burst capture of lpGBT uplink user frames with 32-bit word readout and a
// saturating FEC-corrected frame counter, all in the clk40 domain.
module uplink_frame_capture #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic           clk40_i,
  input  logic           rst_i,
  input  logic           uplinkrdy_i,
  input  logic [233:0]   uplinkUserData_i,
  input  logic           uplinkFEC_i,
  input  logic           arm_i,
  input  logic           abort_i,
  input  logic           trig_mode_i,
  input  logic [31:0]    trig_pattern_i,
  input  logic [31:0]    trig_mask_i,
  input  logic [CW-1:0]  nframes_i,
  uplink_frame_capture_if.master rd,
  output logic [1:0]     state_o,
  output logic [CW-1:0]  frames_stored_o,
  output logic           lost_lock_o,
  output logic [15:0]    fec_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   nframes_q, nframes_d;
  logic [CW-1:0]   stored_q, stored_d;
  logic            lost_q, lost_d;
  logic [15:0]     fec_q, fec_d;
  logic            valid_q, valid_d;
  logic [2:0]      word_q, word_d;
  logic [AW-1:0]   rframe_q, rframe_d;

  logic            we, re;
  logic [AW-1:0]   waddr, raddr;
  logic [233:0]    mem [DEPTH];
  logic [233:0]    rdata_q;

  logic [CW-1:0]   n_clamped;
  logic            trig_hit;
  logic            last_frame;
  logic [255:0]    padded;

  always_comb begin
    if (nframes_i == '0)                n_clamped = CW'(1);
    else if (nframes_i > CW'(DEPTH))    n_clamped = CW'(DEPTH);
    else                                n_clamped = nframes_i;
  end

  assign trig_hit   = uplinkrdy_i &&
                      (!trig_mode_i ||
                       (((uplinkUserData_i[31:0] ^ trig_pattern_i) & trig_mask_i) == 32'd0));
  assign last_frame = ({1'b0, rframe_q} + CW'(1)) == nframes_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    nframes_d = nframes_q;
    stored_d  = stored_q;
    lost_d    = lost_q;
    fec_d     = fec_q;
    valid_d   = valid_q;
    word_d    = word_q;
    rframe_d  = rframe_q;
    we        = 1'b0;
    waddr     = stored_q[AW-1:0];
    re        = 1'b0;
    raddr     = rframe_q + AW'(1);

    if (uplinkrdy_i && uplinkFEC_i && (fec_q != 16'hFFFF)) fec_d = fec_q + 16'd1;

    if (abort_i) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arm_i) begin
            state_d   = S_ARMED;
            nframes_d = n_clamped;
            stored_d  = '0;
            lost_d    = 1'b0;
            fec_d     = '0;
          end
        end
        S_ARMED: begin
          if (trig_hit) begin
            we       = 1'b1;
            waddr    = '0;
            stored_d = CW'(1);
            state_d  = (nframes_q == CW'(1)) ? S_READOUT : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (uplinkrdy_i) begin
            we       = 1'b1;
            stored_d = stored_q + CW'(1);
            if ((stored_q + CW'(1)) == nframes_q) state_d = S_READOUT;
          end else begin
            lost_d = 1'b1;
          end
        end
        S_READOUT: begin
          // First cycle here only fetches frame 0, so a frame written on the entry edge is seen.
          if (!valid_q) begin
            re       = 1'b1;
            raddr    = '0;
            rframe_d = '0;
            word_d   = '0;
            valid_d  = 1'b1;
          end else if (rd.rd_ready_i) begin
            if (word_q == 3'd7) begin
              if (last_frame) begin
                state_d = S_IDLE;
                valid_d = 1'b0;
              end else begin
                re       = 1'b1;
                rframe_d = rframe_q + AW'(1);
                word_d   = '0;
              end
            end else begin
              word_d = word_q + 3'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk40_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      nframes_q <= CW'(1);
      stored_q  <= '0;
      lost_q    <= 1'b0;
      fec_q     <= '0;
      valid_q   <= 1'b0;
      word_q    <= '0;
      rframe_q  <= '0;
    end else begin
      state_q   <= state_d;
      nframes_q <= nframes_d;
      stored_q  <= stored_d;
      lost_q    <= lost_d;
      fec_q     <= fec_d;
      valid_q   <= valid_d;
      word_q    <= word_d;
      rframe_q  <= rframe_d;
    end
  end

  // NOTE: the frame array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk40_i) begin
    if (we) mem[waddr] <= uplinkUserData_i;
    if (re) rdata_q <= mem[raddr];
  end

  assign padded          = {22'b0, rdata_q};
  assign rd.rd_data_o    = valid_q ? padded[{word_q, 5'b0} +: 32] : 32'd0;
  assign rd.rd_valid_o   = valid_q;
  assign rd.rd_last_o    = valid_q && (word_q == 3'd7) && last_frame;

  assign state_o         = state_q;
  assign frames_stored_o = stored_q;
  assign lost_lock_o     = lost_q;
  assign fec_cnt_o       = fec_q;

endmodule

// File: doc/uplink_frame_capture.md
# uplink_frame_capture

Capture buffer sitting directly downstream of the lpGBT-FPGA uplink core in the clk40 domain. It watches the 234-bit uplink user frame stream, waits for an armed trigger (immediate or masked pattern match), stores a programmable burst of consecutive frames, and then streams them out as 32-bit words over a valid/ready handshake. It also keeps a saturating count of FEC-corrected frames. Its outputs feed a CDC FIFO and AXI readout path.

## Interface
- DEPTH, 16: frame buffer capacity in frames; power of two, 2..64.
- CW, $clog2(DEPTH)+1: width of the frame-count fields.
- clk40_i  in  1  uplink frame clock, the clk40_o of the uplink core.
- rst_i  in  1  asynchronous, active-high reset.
- uplinkrdy_i  in  1  uplink locked; a frame is valid on every cycle it is high.
- uplinkUserData_i  in  234  uplink user frame.
- uplinkFEC_i  in  1  FEC-corrected flag for the current frame.
- arm_i  in  1  single-cycle pulse; starts a capture; acted on only in IDLE.
- abort_i  in  1  level; forces IDLE from any state; takes priority over everything else.
- trig_mode_i  in  1  0 = trigger on first valid frame, 1 = trigger on pattern match.
- trig_pattern_i  in  32  match value, compared against uplinkUserData_i[31:0].
- trig_mask_i  in  32  1 = bit participates in the match.
- nframes_i  in  CW  frames to capture; sampled on arm; 0 is treated as 1; values above DEPTH are clamped to DEPTH.
- rd_data_o  out  32  readout word.
- rd_valid_o  out  1  rd_data_o is valid.
- rd_ready_i  in  1  consumer accepts the word.
- rd_last_o  out  1  final word of the burst; qualified by rd_valid_o.
- state_o  out  2  IDLE=0, ARMED=1, CAPTURE=2, READOUT=3.
- frames_stored_o  out  CW  frames written in the current capture.
- lost_lock_o  out  1  sticky; uplinkrdy_i fell during CAPTURE.
- fec_cnt_o  out  16  saturating count of FEC-corrected frames.

## Operation
- IDLE -> ARMED on arm_i. On the same edge: latch the clamped nframes_i, clear frames_stored_o, lost_lock_o and fec_cnt_o.
- ARMED: the trigger fires when uplinkrdy_i is high and either trig_mode_i=0, or ((uplinkUserData_i[31:0] ^ trig_pattern_i) & trig_mask_i) == 0.
  - The trigger frame is stored as frame 0.
  - Next state is READOUT if nframes = 1, otherwise CAPTURE.
- CAPTURE: on each cycle with uplinkrdy_i high, store the frame at index frames_stored_o and increment it.
  - Cycles with uplinkrdy_i low store nothing and set lost_lock_o.
  - When the count reaches nframes, go to READOUT.
- READOUT: each frame is zero-padded to 256 bits as {22'b0, frame} and emitted as 8 words, least significant word first. Word k carries bits [32k+31:32k].
  - Frames are emitted in index order.
  - rd_last_o is high on word 7 of frame nframes-1.
  - Go to IDLE on the handshake of the last word.
- arm_i outside IDLE is ignored.
- abort_i: go to IDLE at the next edge and drop rd_valid_o. Stored data and counters are kept.
- fec_cnt_o: increments in every state on cycles with uplinkrdy_i & uplinkFEC_i, and saturates at 0xFFFF.
- The buffer must be implementable as a simple dual-port RAM (one write port, one read port with a registered read).

## Timing
- Reset values: state_o=0, rd_data_o=0, rd_valid_o=0, rd_last_o=0, frames_stored_o=0, lost_lock_o=0, fec_cnt_o=0.
- State transitions:
  - arm_i sampled at edge n -> state_o=1 after edge n.
  - Trigger frame sampled at edge t -> it is stored and the state changes at that edge.
- The first rd_valid_o rises no later than 2 cycles after entering READOUT.
- Handshake:
  - A word transfers on an edge where rd_valid_o & rd_ready_i.
  - rd_data_o and rd_last_o are held stable while rd_valid_o & !rd_ready_i.
  - rd_valid_o never drops without a transfer, except on abort_i.
- Back-to-back transfers at one word per cycle are required while rd_ready_i is held high: a burst of N frames takes 8N cycles plus at most 2 cycles of start-up.
- The frame stored on the edge that enters READOUT is readable.
- Reset asserted mid-operation clears all state asynchronously. Deassertion is synchronized to clk40_i by the integrator.

## Test plan
- Immediate mode, nframes=3, incrementing frames F0..F2, rd_ready_i=1 -> 24 words. Word 0 = F0[31:0], word 7 = {22'b0, F0[233:224]}. rd_last_o only on word 23. State then returns to 0.
- Pattern mode, pattern 0x0000_A5A5, mask 0x0000_FFFF, match arriving on the 5th frame -> frame 0 read back equals the 5th frame. No capture before the match.
- nframes_i=0, then nframes_i=DEPTH+5 -> exactly 1 frame captured, then exactly DEPTH frames captured.
- uplinkrdy_i low for 2 cycles during CAPTURE -> lost_lock_o=1, those cycles are skipped, frames_stored_o still reaches nframes.
- rd_ready_i toggling in a 1-0-0-1 pattern -> no word is lost or duplicated, and rd_data_o is stable while stalled. abort_i mid-readout -> rd_valid_o=0 next cycle, state_o=0.
- uplinkFEC_i held high for 70000 valid cycles -> fec_cnt_o=0xFFFF. A subsequent arm_i -> fec_cnt_o=0.
